spi_adc_slave: RTL and testbench
================================

// Module: spi_adc_slave
// PURPOSE
//  Synthesizable serial-ADC emulator: SPI slave that drives sdo to the write_led reader, one frame per cs-low window.
//  Parallel samples enter via a valid/ready holding register; each frame is MSB first, LEAD_ZEROS zeros, DATA_W data, zero pad.
//  Sits directly upstream of write_led (consumes its cs/sck, produces its sdo); replaces the behavioural bench model in on-board loopback.
// PARAMETERS
//  FRAME_W     16  bits per frame; FRAME_W >= LEAD_ZEROS + DATA_W
//  LEAD_ZEROS  3   leading zero bits before data
//  DATA_W      8   sample width; frame = {LEAD_ZEROS'b0, sample, (FRAME_W-LEAD_ZEROS-DATA_W)'b0}
//  SYNC_STAGES 2   flops per synchronizer on cs and sck (>= 2)
// PORTS
//  clk           in   1       system clock; all logic on posedge clk
//  rst           in   1       synchronous, active-high reset
//  cs            in   1       chip select from master, active low, asynchronous to clk
//  sck           in   1       serial clock from master, asynchronous to clk; master samples sdo on rising sck
//  sdo           out  1       serial data to master
//  sample_in     in   DATA_W  next sample
//  sample_valid  in   1       sample_in valid
//  sample_ready  out  1       holding register can accept; transfer when valid && ready
//  frame_done    out  1       1-cycle pulse: cs rose after all FRAME_W bits shifted
//  short_frame   out  1       1-cycle pulse: cs rose before FRAME_W bits shifted (aborted frame)
//  underrun      out  1       1-cycle pulse: frame started with holding register empty (last sample resent)
// BEHAVIOUR
//  Reset: sdo=0, sample_ready=1, frame_done=short_frame=underrun=0; hold and last-sample regs 0; FSM IDLE; armed=0.
//  Sync flops reset to 1 (cs idle high, sck idle high). Edges detected on last two sync stages -> one-cycle strobes.
//  armed sets once synced cs seen high; a cs falling edge with armed=0 is ignored (cs held low across reset => no frame).
//  Holding reg: sample_ready = !hold_full. Accept -> hold <= sample_in, hold_full <= 1.
//  FSM IDLE: sdo=0. On cs_fall && armed -> SHIFT: shreg <= frame(hold_full ? hold : last), last <= chosen sample,
//    hold_full <= 0, bitcnt <= 0, sdo = frame MSB from next cycle. If hold_full=0: underrun pulse same cycle.
//  Accept on the same cycle as cs_fall with hold empty: frame sends last (underrun), new sample stored in hold.
//  SHIFT: on sck_fall: shreg <<= 1, bitcnt++, sdo = new MSB; when bitcnt reaches FRAME_W-1 and sck falls -> TAIL.
//  TAIL: sdo=0; further sck edges ignored (no wrap into a second frame within one cs window).
//  Any state, cs_rise -> IDLE, sdo=0 next cycle; pulse frame_done if state==TAIL, else short_frame if SHIFT.
//  cs_rise and sck_fall same cycle: cs_rise wins, no shift. Accept during SHIFT/TAIL allowed (loads hold, not shreg).
//  Latency: sdo updates SYNC_STAGES+1 clk after pin sck falls. Requirement: each sck half-period >= SYNC_STAGES+3 clk.
//  rst mid-frame: immediate IDLE; remainder of that cs window ignored (armed=0 until cs high).
// STRUCTURE
//  Shared package spi_pkg: state encoding (IDLE/SHIFT/TAIL), FRAME_W/LEAD_ZEROS/DATA_W defaults, frame-build function.
//  Sub-module sync_edge (SYNC_STAGES flops + rise/fall strobes, reset value parameter), instanced for cs and sck.
//  Top holds holding reg, FSM, shreg, bitcnt (clog2(FRAME_W+1) bits), pulse outputs.
// TESTING
//  Load 8'hF7, drop cs, 16 sck cycles -> master captures 16'b0001_1110_1110_0000; frame_done=1 one cycle after cs_rise sync.
//  Two frames, load 8'hA5 only before first -> 2nd frame resends 0001_0100_1010_0000, underrun pulse at 2nd cs_fall.
//  Drop cs, 5 sck cycles, raise cs -> short_frame pulse, sdo=0, next frame restarts at MSB with bitcnt=0.
//  20 sck cycles in one cs window -> bits 16..19 read 0, no wrap, frame_done on cs_rise.
//  Assert rst at bit 7 with cs low -> sdo=0, no output for rest of window; next full window sends held-in sample normally.
//  sample_valid held high with cs_fall same cycle, hold empty -> underrun, new sample sent in following frame.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the serial-ADC emulator: state encoding,
// default frame geometry and the frame-build helper.
package spi_pkg;

    localparam int FRAME_W_DEF     = 16;
    localparam int LEAD_ZEROS_DEF  = 3;
    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } spi_state_t;

    // Places a sample inside a frame: lead_zeros zeros, data_w data bits,
    // then zero padding. The frame sits in the low frame_w bits of the
    // 64-bit result, so callers size-cast down to their own frame width.
    function automatic logic [63:0] build_frame(input logic [63:0] sample,
                                                input int frame_w,
                                                input int lead_zeros,
                                                input int data_w);
        logic [63:0] mask;
        mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        return (sample & mask) << (frame_w - lead_zeros - data_w);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with registered
// one-cycle rise/fall strobes taken from the last two stages.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_rise;
    logic              r_fall;

    // Shift the pin through the chain (bit 0 newest) and flag edges between the two oldest stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_rise <= r_sync[STAGES-2] & ~r_sync[STAGES-1];
            r_fall <= ~r_sync[STAGES-2] & r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_adc_slave.sv
// Serial-ADC emulator: SPI slave that shifts one frame per cs-low window.
// Samples arrive through a valid/ready holding register; each frame is
// MSB first: leading zeros, the sample, then zero padding. Data changes
// on falling sck so the master can sample on rising sck.
module spi_adc_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W     = FRAME_W_DEF,
    parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic              i_sck,
    output logic              o_sdo,
    input  logic [DATA_W-1:0] i_sample_in,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    output logic              o_frame_done,
    output logic              o_short_frame,
    output logic              o_underrun
);

    localparam int              CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_level;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_unused_sck;

    spi_state_t r_state;
    spi_state_t w_next_state;

    logic [DATA_W-1:0]  r_hold;
    logic               r_hold_full;
    logic [DATA_W-1:0]  r_last;
    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_sdo;
    logic               r_frame_done;
    logic               r_short_frame;
    logic               r_underrun;
    logic               r_armed;
    logic [SYNC_STAGES:0] r_settle;

    logic               w_accept;
    logic [DATA_W-1:0]  w_chosen;
    logic [FRAME_W-1:0] w_frame;
    logic               w_start;
    logic               w_shift;
    logic               w_done;
    logic               w_short;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cs),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sck_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // Only falling sck matters here; the other synchronizer outputs are left idle.
    assign w_unused_sck = w_sck_level ^ w_sck_rise;

    assign w_accept       = i_sample_valid & ~r_hold_full;
    assign w_chosen       = r_hold_full ? r_hold : r_last;
    assign w_frame        = FRAME_W'(build_frame(64'(w_chosen), FRAME_W, LEAD_ZEROS, DATA_W));
    assign o_sample_ready = ~r_hold_full;

    // State register for the frame sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a cs rise overrides any sck activity in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        w_short      = 1'b0;
        if (w_cs_rise) begin
            w_next_state = ST_IDLE;
            w_done       = (r_state == ST_TAIL);
            w_short      = (r_state == ST_SHIFT);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall && r_armed) begin
                        w_next_state = ST_SHIFT;
                        w_start      = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_sck_fall) begin
                        if (r_bitcnt == LAST_BIT) begin
                            w_next_state = ST_TAIL;
                        end else begin
                            w_shift = 1'b1;
                        end
                    end
                end
                ST_TAIL: begin
                    w_next_state = ST_TAIL;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Arming waits until the cs synchronizer has refilled from the pin after reset,
    // so a cs already low during reset never looks like a fresh frame start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            if (r_settle[SYNC_STAGES] && w_cs_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Holding register: a new sample may land on the same cycle the old contents are consumed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_last      <= '0;
        end else begin
            if (w_accept) begin
                r_hold      <= i_sample_in;
                r_hold_full <= 1'b1;
            end else if (w_start) begin
                r_hold_full <= 1'b0;
            end
            if (w_start) begin
                r_last <= w_chosen;
            end
        end
    end

    // Shift path: load on frame start, advance on each falling sck, park sdo low otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_sdo    <= 1'b0;
        end else begin
            if (w_start) begin
                r_shreg  <= w_frame;
                r_bitcnt <= '0;
                r_sdo    <= w_frame[FRAME_W-1];
            end else if (w_shift) begin
                r_shreg  <= r_shreg << 1;
                r_bitcnt <= r_bitcnt + CNT_W'(1);
                r_sdo    <= r_shreg[FRAME_W-2];
            end else if (w_next_state != ST_SHIFT) begin
                r_sdo <= 1'b0;
            end
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_done  <= w_done;
            r_short_frame <= w_short;
            r_underrun    <= w_start & ~r_hold_full;
        end
    end

    assign o_sdo         = r_sdo;
    assign o_frame_done  = r_frame_done;
    assign o_short_frame = r_short_frame;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_spi_adc_slave.sv
// Bench for spi_adc_slave: acts as the SPI master (sck idles low, data
// read just before each rising sck), keeps a sample-level model of the
// holding/last registers and checks every frame against it.
module tb_spi_adc_slave;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int H  = 6;

    logic          clk;
    logic          rst;
    logic          cs;
    logic          sck;
    logic          sampleValid;
    logic [DW-1:0] sampleIn;
    logic          sdo;
    logic          sampleReady;
    logic          frameDone;
    logic          shortFrame;
    logic          underrun;

    int testsRun    = 0;
    int testsFailed = 0;
    int nDone       = 0;
    int nShort      = 0;
    int nUnder      = 0;

    logic [7:0] mHold;
    logic [7:0] mLast;
    logic       mHoldFull;
    logic       chkEn;

    string       reqName;
    logic [31:0] reqAct;
    logic [31:0] reqExp;
    int          reqSeq = 0;
    int          ackSeq = 0;

    spi_adc_slave #(
        .FRAME_W     (16),
        .LEAD_ZEROS  (3),
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cs           (cs),
        .i_sck          (sck),
        .o_sdo          (sdo),
        .i_sample_in    (sampleIn),
        .i_sample_valid (sampleValid),
        .o_sample_ready (sampleReady),
        .o_frame_done   (frameDone),
        .o_short_frame  (shortFrame),
        .o_underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The frame a sample must produce: three zeros, the sample, five zeros.
    function automatic logic [15:0] modelFrame(input logic [7:0] s);
        return {3'b000, s, 5'b00000};
    endfunction

    // Compare process: counts pulse cycles, checks idle outputs against the model,
    // and performs every comparison posted by the stimulus thread.
    always @(negedge clk) begin
        if (frameDone === 1'b1) nDone++;
        if (shortFrame === 1'b1) nShort++;
        if (underrun === 1'b1) nUnder++;
        if (chkEn) begin
            testsRun++;
            if (sdo !== 1'b0 || sampleReady !== ~mHoldFull) begin
                testsFailed++;
                $display("[TB] FAIL idleOutputs at %0t: sdo=%b ready=%b, required sdo=0 ready=%b",
                         $time, sdo, sampleReady, ~mHoldFull);
            end
        end
        if (ackSeq != reqSeq) begin
            testsRun++;
            if (reqAct !== reqExp) begin
                testsFailed++;
                $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", reqName, reqAct, reqExp);
            end
            ackSeq = reqSeq;
        end
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        reqName = nm;
        reqAct  = act;
        reqExp  = exp;
        reqSeq++;
        wait (ackSeq == reqSeq);
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers one sample for a single cycle; the model takes it only if the hold is empty.
    task automatic loadSample(input logic [7:0] v);
        sampleValid = 1'b1;
        sampleIn    = v;
        @(posedge clk);
        if (!mHoldFull) begin
            mHold     = v;
            mHoldFull = 1'b1;
        end
        @(negedge clk);
        sampleValid = 1'b0;
    endtask

    // One cs-low window with nSck clocks; optional reset or sample load during
    // the high half of a given bit, optional load aligned with the frame start.
    task automatic applyStimulus(input string nm, input int nSck, input int rstAt,
                                 input int loadAt, input logic [7:0] loadVal,
                                 input logic sameLoad, output logic [31:0] cap);
        logic [31:0] expBits;
        logic [15:0] frame;
        logic [7:0]  sent;
        logic        expU;
        logic        didRst;
        int          d0;
        int          s0;
        int          u0;
        chkEn   = 1'b0;
        didRst  = 1'b0;
        cap     = '0;
        expBits = '0;
        d0 = nDone;
        s0 = nShort;
        u0 = nUnder;
        if (mHoldFull) begin
            sent = mHold;
            expU = 1'b0;
        end else begin
            sent = mLast;
            expU = 1'b1;
        end
        mLast     = sent;
        mHoldFull = 1'b0;
        frame     = modelFrame(sent);
        cs = 1'b0;
        if (sameLoad) begin
            repeat (SS) @(posedge clk);
            @(negedge clk);
            sampleValid = 1'b1;
            sampleIn    = loadVal;
            @(posedge clk);
            if (expU) begin
                mHold     = loadVal;
                mHoldFull = 1'b1;
            end
            @(negedge clk);
            sampleValid = 1'b0;
        end
        waitNeg(H);
        for (int k = 0; k < nSck; k++) begin
            cap = {cap[30:0], sdo};
            sck = 1'b1;
            if (k == rstAt) begin
                rst = 1'b1;
                @(negedge clk);
                rst       = 1'b0;
                mHold     = '0;
                mLast     = '0;
                mHoldFull = 1'b0;
                didRst    = 1'b1;
                waitNeg(H - 1);
            end else if (k == loadAt) begin
                loadSample(loadVal);
                waitNeg(H - 1);
            end else begin
                waitNeg(H);
            end
            sck = 1'b0;
            waitNeg(H);
        end
        cs = 1'b1;
        waitNeg(2 * SS + 8);
        for (int k = 0; k < nSck; k++) begin
            expBits = {expBits[30:0], ((didRst && k > rstAt) || k >= 16) ? 1'b0 : frame[15-k]};
        end
        checkOutput({nm, "_bits"}, cap, expBits);
        checkOutput({nm, "_frameDone"}, 32'(nDone - d0), 32'(nSck >= 16 && !didRst));
        checkOutput({nm, "_shortFrame"}, 32'(nShort - s0), 32'(nSck < 16 && !didRst));
        checkOutput({nm, "_underrun"}, 32'(nUnder - u0), 32'(expU));
        chkEn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] cap;
        int          base;
        rst         = 1'b1;
        cs          = 1'b0;
        sck         = 1'b0;
        sampleValid = 1'b0;
        sampleIn    = '0;
        chkEn       = 1'b0;
        mHold       = '0;
        mLast       = '0;
        mHoldFull   = 1'b0;
        waitNeg(3);
        checkOutput("resetSdo", 32'(sdo), 32'd0);
        checkOutput("resetReady", 32'(sampleReady), 32'd1);
        checkOutput("resetPulses", 32'({frameDone, shortFrame, underrun}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chkEn = 1'b1;

        // cs already low through reset: a whole burst of sck must produce nothing.
        base = nDone + nShort + nUnder;
        cap  = '0;
        for (int k = 0; k < 16; k++) begin
            cap = {cap[30:0], sdo};
            sck = 1'b1;
            waitNeg(H);
            sck = 1'b0;
            waitNeg(H);
        end
        cs = 1'b1;
        waitNeg(2 * SS + 8);
        checkOutput("csLowAcrossReset_bits", cap, 32'd0);
        checkOutput("csLowAcrossReset_pulses", 32'(nDone + nShort + nUnder - base), 32'd0);

        checkOutput("modelPinF7", 32'(modelFrame(8'hF7)), 32'b0001_1110_1110_0000);

        loadSample(8'hF7);
        applyStimulus("frameF7", 16, -1, -1, 8'h00, 1'b0, cap);
        checkOutput("literalF7", cap, 32'b0001_1110_1110_0000);

        loadSample(8'hA5);
        applyStimulus("frameA5", 16, -1, -1, 8'h00, 1'b0, cap);
        applyStimulus("resendA5", 16, -1, -1, 8'h00, 1'b0, cap);
        checkOutput("literalResendA5", cap, 32'b0001_0100_1010_0000);

        loadSample(8'hC3);
        applyStimulus("short5", 5, -1, -1, 8'h00, 1'b0, cap);
        loadSample(8'h81);
        applyStimulus("afterShort", 16, -1, -1, 8'h00, 1'b0, cap);
        checkOutput("literalAfterShort", cap, 32'b0001_0000_0010_0000);

        loadSample(8'hFF);
        applyStimulus("long20", 20, -1, -1, 8'h00, 1'b0, cap);
        checkOutput("literalLong20", cap, 32'b0001_1111_1110_0000_0000);

        loadSample(8'h6B);
        applyStimulus("resetMid", 16, 7, -1, 8'h00, 1'b0, cap);
        loadSample(8'h3C);
        applyStimulus("afterReset", 16, -1, -1, 8'h00, 1'b0, cap);

        applyStimulus("sameCycleLoad", 16, -1, -1, 8'h5A, 1'b1, cap);
        applyStimulus("sendsSameCycle", 16, -1, -1, 8'h00, 1'b0, cap);
        checkOutput("literalSameCycle", cap, 32'b0000_1011_0100_0000);

        applyStimulus("loadDuringShift", 16, -1, 4, 8'h99, 1'b0, cap);
        applyStimulus("sendsMidLoad", 16, -1, -1, 8'h00, 1'b0, cap);

        // Random mix of loads, frame lengths and loads placed inside a frame.
        for (int it = 0; it < 24; it++) begin
            int   r;
            int   nS;
            int   la;
            logic sl;
            r = int'($urandom_range(0, 3));
            if (r != 0) loadSample(8'($urandom_range(0, 255)));
            if (r == 3) loadSample(8'($urandom_range(0, 255)));
            nS = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : 16;
            la = -1;
            if (nS > 0 && $urandom_range(0, 3) == 0) la = int'($urandom_range(0, nS - 1));
            sl = (!mHoldFull && la < 0 && $urandom_range(0, 3) == 0);
            applyStimulus("random", nS, -1, la, 8'($urandom_range(0, 255)), sl, cap);
        end

        chkEn = 1'b0;
        waitNeg(4);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
